// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore datapath strobes per state, plus Mealy retire and illegal-opcode pulses.
// Outputs are combinational from the state register; FETCH, MEMRD and MEMWR hold until mem_ready.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    EXEC_I = 4'd9,
    JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t cur, nxt;
  logic   is_lw_q, is_r_q, is_logic_q;

  // Opcode class bits are captured in DECODE only, so later opcode changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= FETCH;
      is_lw_q    <= 1'b0;
      is_r_q     <= 1'b0;
      is_logic_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) begin
        is_lw_q    <= (opcode == OP_LW);
        is_r_q     <= (opcode == OP_R);
        is_logic_q <= (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_SLTI);
      end
    end
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      nxt = MEMADR;
          OP_R:                              nxt = EXEC_R;
          OP_BEQ:                            nxt = BRANCH;
          OP_J:                              nxt = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = EXEC_I;
          default:                           nxt = FETCH;
        endcase
      end
      MEMADR: nxt = is_lw_q ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXEC_R: nxt = ALUWB;
      EXEC_I: nxt = ALUWB;
      default: nxt = FETCH;
    endcase
  end

  assign state = cur;

  // Every strobe is gated by rst_n so an asserted reset silences the outputs without waiting for a clock.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    aluop         = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (cur)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal_op = 1'b0;
            default:                           illegal_op = 1'b1;
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          aluop     = 2'b10;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluop     = is_logic_q ? 2'b11 : 2'b00;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = is_r_q;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          aluop         = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle against hand-computed strobes.
module tb_multicycle_control;

  logic       clk, rst_n, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source, aluop;
  logic [3:0] state;

  int vectors     = 0;
  int miscompares = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluop(aluop), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, aluop, instr_done, illegal_op}
  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                 aluop, instr_done, illegal_op};

  localparam logic [17:0] E_ZERO    = 18'h00000;
  localparam logic [17:0] E_FETCH   = 18'h25040; // mem_ready=1
  localparam logic [17:0] E_FETCH_S = 18'h04040; // mem_ready=0
  localparam logic [17:0] E_DEC     = 18'h000C0;
  localparam logic [17:0] E_DEC_ILL = 18'h000C1;
  localparam logic [17:0] E_MEMADR  = 18'h00180;
  localparam logic [17:0] E_MEMRD   = 18'h0C000;
  localparam logic [17:0] E_MEMWB   = 18'h00A02;
  localparam logic [17:0] E_MEMWR_S = 18'h0A000;
  localparam logic [17:0] E_MEMWR   = 18'h0A002;
  localparam logic [17:0] E_EXEC_R  = 18'h00108;
  localparam logic [17:0] E_ALUWB_R = 18'h00602;
  localparam logic [17:0] E_ALUWB_I = 18'h00202;
  localparam logic [17:0] E_EXEC_AD = 18'h00180;
  localparam logic [17:0] E_EXEC_LG = 18'h0018C;
  localparam logic [17:0] E_BRANCH  = 18'h10116;
  localparam logic [17:0] E_JUMP    = 18'h20022;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle (inputs already applied), then advance to 2 ns after the next rising edge.
  task automatic step(input string tag, input logic [3:0] es, input logic [17:0] eo);
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
    chk({tag, ".outs"},  {14'd0, outs},  {14'd0, eo});
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
    #3;
    chk("reset.state", {28'd0, state}, 32'd0);
    chk("reset.outs",  {14'd0, outs},  {14'd0, E_ZERO});
    @(posedge clk); #2;
    chk("reset_clk.outs", {14'd0, outs}, {14'd0, E_ZERO});
    rst_n = 1'b1;

    // R-type; opcode switched to addi after DECODE must not alter reg_dst in ALUWB
    step("r.fetch", 4'd0, E_FETCH);
    step("r.decode", 4'd1, E_DEC);
    opcode = 6'b001000;
    step("r.exec", 4'd6, E_EXEC_R);
    step("r.aluwb", 4'd7, E_ALUWB_R);

    // lw with a FETCH stall, opcode corrupted in MEMADR, three MEMRD stall cycles
    opcode = 6'b100011; mem_ready = 1'b0;
    step("lw.fetch_stall", 4'd0, E_FETCH_S);
    mem_ready = 1'b1;
    step("lw.fetch", 4'd0, E_FETCH);
    step("lw.decode", 4'd1, E_DEC);
    opcode = 6'b101011; mem_ready = 1'b0;
    step("lw.memadr", 4'd2, E_MEMADR);
    step("lw.memrd_s1", 4'd3, E_MEMRD);
    step("lw.memrd_s2", 4'd3, E_MEMRD);
    step("lw.memrd_s3", 4'd3, E_MEMRD);
    mem_ready = 1'b1;
    step("lw.memrd", 4'd3, E_MEMRD);
    step("lw.memwb", 4'd4, E_MEMWB);

    // sw with one MEMWR stall cycle; retire only when mem_ready
    opcode = 6'b101011;
    step("sw.fetch", 4'd0, E_FETCH);
    step("sw.decode", 4'd1, E_DEC);
    mem_ready = 1'b0;
    step("sw.memadr", 4'd2, E_MEMADR);
    step("sw.memwr_s", 4'd5, E_MEMWR_S);
    mem_ready = 1'b1;
    step("sw.memwr", 4'd5, E_MEMWR);

    opcode = 6'b000100;
    step("beq.fetch", 4'd0, E_FETCH);
    step("beq.decode", 4'd1, E_DEC);
    step("beq.branch", 4'd8, E_BRANCH);

    opcode = 6'b000010;
    step("j.fetch", 4'd0, E_FETCH);
    step("j.decode", 4'd1, E_DEC);
    step("j.jump", 4'd10, E_JUMP);

    opcode = 6'b001101;
    step("ori.fetch", 4'd0, E_FETCH);
    step("ori.decode", 4'd1, E_DEC);
    step("ori.exec", 4'd9, E_EXEC_LG);
    step("ori.aluwb", 4'd7, E_ALUWB_I);

    opcode = 6'b001000;
    step("addi.fetch", 4'd0, E_FETCH);
    step("addi.decode", 4'd1, E_DEC);
    opcode = 6'b001101;
    step("addi.exec", 4'd9, E_EXEC_AD);
    step("addi.aluwb", 4'd7, E_ALUWB_I);

    opcode = 6'b111111;
    step("ill.fetch", 4'd0, E_FETCH);
    step("ill.decode", 4'd1, E_DEC_ILL);
    mem_ready = 1'b0;
    step("ill.refetch", 4'd0, E_FETCH_S);

    // sw aborted by reset while stalled in MEMWR
    opcode = 6'b101011; mem_ready = 1'b1;
    step("rst.fetch", 4'd0, E_FETCH);
    step("rst.decode", 4'd1, E_DEC);
    mem_ready = 1'b0;
    step("rst.memadr", 4'd2, E_MEMADR);
    #1;
    chk("rst.memwr.state", {28'd0, state}, 32'd5);
    chk("rst.memwr.outs",  {14'd0, outs},  {14'd0, E_MEMWR_S});
    rst_n = 1'b0;
    #1;
    chk("rst.async.state", {28'd0, state}, 32'd0);
    chk("rst.async.outs",  {14'd0, outs},  {14'd0, E_ZERO});
    mem_ready = 1'b1;
    @(posedge clk); #2;
    chk("rst.held.outs", {14'd0, outs}, {14'd0, E_ZERO});
    rst_n = 1'b1;
    step("rst.after.fetch", 4'd0, E_FETCH);
    step("rst.after.decode", 4'd1, E_DEC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have ports: opcode input 6, instruction[31:26] from the instruction register; mem_ready input 1, memory access complete this cycle.
REQ-003 SHALL have ports, each output 1 bit: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-004 SHALL have ports: alu_src_b output 2; pc_source output 2; aluop output 2, driving the aluop input of AluControl; state output 4, current state code.
REQ-005 SHALL have ports: instr_done output 1, retire pulse; illegal_op output 1, undecodable-opcode pulse.

Function
REQ-006 SHALL implement a state register with the following codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB=7, BRANCH=8, EXEC_I=9, JUMP=10; codes 11-15 are unused and SHALL go to FETCH on the next edge.
REQ-007 SHALL decode these opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101, slti=001010.
REQ-008 SHALL apply these transitions:
- FETCH->DECODE only when mem_ready=1; otherwise stay in FETCH.
- DECODE->MEMADR for lw/sw; ->EXEC_R for R; ->BRANCH for beq; ->JUMP for j; ->EXEC_I for addi/andi/ori/slti; ->FETCH for any other opcode.
- MEMADR->MEMRD for lw; MEMADR->MEMWR for sw.
- MEMRD->MEMWB only when mem_ready=1; otherwise stay in MEMRD.
- MEMWR->FETCH only when mem_ready=1; otherwise stay in MEMWR.
- EXEC_R->ALUWB; EXEC_I->ALUWB; MEMWB, ALUWB, BRANCH and JUMP ->FETCH.
REQ-009 SHALL sample opcode only in DECODE; in MEMADR and ALUWB it SHALL use an opcode-class bit registered in DECODE, so opcode changes after DECODE have no effect.
REQ-010 SHALL decode outputs combinationally from state (Moore), except for the Mealy pulses in REQ-011/012/013; any output not listed for a state is 0.
REQ-011 SHALL drive FETCH as: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00; ir_write=pc_write=mem_ready.
REQ-012 SHALL drive the remaining states as:
- DECODE: alu_src_a=0, alu_src_b=11, aluop=00.
- MEMADR: alu_src_a=1, alu_src_b=10, aluop=00.
- MEMRD: mem_read=1, iord=1.
- MEMWR: mem_write=1, iord=1.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
- EXEC_R: alu_src_a=1, alu_src_b=00, aluop=10.
- EXEC_I: alu_src_a=1, alu_src_b=10; aluop=00 for addi, 11 for andi/ori/slti.
- ALUWB: reg_write=1, mem_to_reg=0; reg_dst=1 for R, 0 for I-type.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
REQ-013 SHALL pulse instr_done=1 for exactly one cycle in MEMWB, ALUWB, BRANCH, JUMP, and in MEMWR in the cycle mem_ready=1; SHALL pulse illegal_op=1 in DECODE when the opcode is undecodable.
REQ-014 SHALL hold mem_read/mem_write/iord stable for every cycle of a mem_ready stall.
REQ-015 SHALL never assert mem_read and mem_write together, nor reg_write with pc_write in the same cycle.

Reset
REQ-016 SHALL, while rst_n=0, force state=FETCH and all outputs to 0, regardless of clk.
REQ-017 SHALL, on deassertion of rst_n, begin in FETCH with FETCH outputs on the first cycle; an asynchronous reset mid-instruction (e.g. in MEMWR) SHALL abort it with no further write strobes.

Verification
REQ-018 SHALL cover: reset, then R opcode 000000 with mem_ready=1 -> states 0,1,6,7,0; aluop=10 in EXEC_R; reg_dst=1 and reg_write=1 in ALUWB; instr_done once.
REQ-019 SHALL cover: lw 100011 with mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; mem_read=1 and iord=1 held throughout the stall.
REQ-020 SHALL cover: beq 000100 -> BRANCH with aluop=01, pc_write_cond=1, pc_source=01; j 000010 -> JUMP with pc_write=1, pc_source=10.
REQ-021 SHALL cover: ori 001101 -> EXEC_I with aluop=11; addi 001000 -> EXEC_I with aluop=00; reg_dst=0 in ALUWB for both.
REQ-022 SHALL cover: opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, no write strobe; rst_n=0 during MEMWR -> all outputs 0 immediately, state=0.
